pipelined_wallace_multiplier: RTL and testbench

- Parametrised, pipelined successor to the combinational 32x32 Wallace-tree multiplier.
- Multiplies two WIDTH-bit operands to a 2*WIDTH-bit product; per-transaction signed/unsigned mode.
- Four register stages with valid/ready handshakes on both sides and a pass-through tag.
- Sits between operand issue logic and result writeback in the datapath; accepts one operation per cycle at full throughput.

---
 rtl/pipelined_wallace_multiplier.sv | 159 +++++++++++++++
 tb/tb_pipelined_wallace_multiplier.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_wallace_multiplier.sv
// Four-stage elastic signed/unsigned multiplier.
// Operand magnitudes, then carry-save tree, then prefix adder, then sign fix-up.
module pipelined_wallace_multiplier #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int LG = $clog2(PW);

  logic             r_v1, r_v2, r_v3, r_v4;
  logic [WIDTH-1:0] r_a1, r_b1;
  logic             r_n1, r_n2, r_n3;
  logic [TAG_W-1:0] r_t1, r_t2, r_t3, r_t4;
  logic [PW-1:0]    r_s2, r_c2, r_p3, r_p4;

  logic             w_adv1, w_adv2, w_adv3, w_adv4;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_neg;
  logic [PW-1:0]    w_sum, w_cry, w_add;

  assign w_adv4 = ~r_v4 | out_ready;
  assign w_adv3 = ~r_v3 | w_adv4;
  assign w_adv2 = ~r_v2 | w_adv3;
  assign w_adv1 = ~r_v1 | w_adv2;

  assign in_ready  = w_adv1;
  assign out_valid = r_v4;
  assign out_p     = r_p4;
  assign out_tag   = r_t4;

  assign w_mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign w_neg   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  // 3:2 compressor levels until two rows remain
  always_comb begin : csa_tree
    logic [PW-1:0] v  [WIDTH];
    logic [PW-1:0] nv [WIDTH];
    int n;
    int m;
    n = WIDTH;
    m = 0;
    for (int i = 0; i < WIDTH; i++) begin
      v[i]  = r_b1[i] ? (PW'(r_a1) << i) : '0;
      nv[i] = '0;
    end
    for (int l = 0; l < WIDTH; l++) begin
      if (n > 2) begin
        m = 0;
        for (int k = 0; k < WIDTH; k++) nv[k] = '0;
        for (int j = 0; j < WIDTH; j += 3) begin
          if (j + 2 < n) begin
            nv[m]     = v[j] ^ v[j+1] ^ v[j+2];
            nv[m + 1] = ((v[j] & v[j+1]) |
                         (v[j] & v[j+2]) |
                         (v[j+1] & v[j+2])) << 1;
            m += 2;
          end else if (j < n) begin
            nv[m] = v[j];
            m += 1;
            if (j + 1 < n) begin
              nv[m] = v[j+1];
              m += 1;
            end
          end
        end
        v = nv;
        n = m;
      end
    end
    w_sum = v[0];
    w_cry = v[1];
  end

  always_comb begin : ks_adder
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    g = r_s2 & r_c2;
    p = r_s2 ^ r_c2;
    for (int k = 0; k < LG; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & (p << (1 << k));
    end
    w_add = r_s2 ^ r_c2 ^ (g << 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
      r_n1 <= 1'b0;
      r_t1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      r_a1 <= w_mag_a;
      r_b1 <= w_mag_b;
      r_n1 <= w_neg;
      r_t1 <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
      r_c2 <= '0;
      r_n2 <= 1'b0;
      r_t2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      r_s2 <= w_sum;
      r_c2 <= w_cry;
      r_n2 <= r_n1;
      r_t2 <= r_t1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3 <= 1'b0;
      r_p3 <= '0;
      r_n3 <= 1'b0;
      r_t3 <= '0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      r_p3 <= w_add;
      r_n3 <= r_n2;
      r_t3 <= r_t2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v4 <= 1'b0;
      r_p4 <= '0;
      r_t4 <= '0;
    end else if (w_adv4) begin
      r_v4 <= r_v3;
      r_p4 <= r_n3 ? -r_p3 : r_p3;
      r_t4 <= r_t3;
    end
  end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Bench for pipelined_wallace_multiplier: 32-bit directed/random/backpressure/reset,
// plus exhaustive 8-bit signed+unsigned sweep and random 16-bit alongside.
module tb_pipelined_wallace_multiplier;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [63:0] out_p;

  logic        s_valid, s_oready;
  logic [7:0]  s_a8, s_b8;
  logic [15:0] s_a16, s_b16;
  logic        s_sg16;
  logic [3:0]  s_tag;
  logic        r8s, r8u, r16, v8s, v8u, v16;
  logic [15:0] p8s, p8u;
  logic [31:0] p16;
  logic        t8s, t8u;
  logic [3:0]  t16;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  exp_t q32[$], q8s[$], q8u[$], q16[$];

  pipelined_wallace_multiplier #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag));

  pipelined_wallace_multiplier #(.WIDTH(8), .TAG_W(1)) u_dut8s (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(r8s),
    .in_a(s_a8), .in_b(s_b8), .in_signed(1'b1), .in_tag(s_tag[0]),
    .out_valid(v8s), .out_ready(s_oready),
    .out_p(p8s), .out_tag(t8s));

  pipelined_wallace_multiplier #(.WIDTH(8), .TAG_W(1)) u_dut8u (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(r8u),
    .in_a(s_a8), .in_b(s_b8), .in_signed(1'b0), .in_tag(s_tag[0]),
    .out_valid(v8u), .out_ready(s_oready),
    .out_p(p8u), .out_tag(t8u));

  pipelined_wallace_multiplier #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(r16),
    .in_a(s_a16), .in_b(s_b16), .in_signed(s_sg16), .in_tag(s_tag),
    .out_valid(v16), .out_ready(s_oready),
    .out_p(p16), .out_tag(t16));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: integer product of the interpreted operands, modulo 2^(2w)
  function automatic logic [63:0] mref(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic s, input int w);
    longint sa, sb;
    logic [63:0] m;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    m = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(sa * sb) & m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q32.delete();
    end else begin
      if (out_valid) begin
        if (q32.size() == 0) chk("extra32", 64'd1, 64'd0);
        else begin
          e = q32[0];
          chk("p32", out_p, e.p);
          chk("tag32", 64'(out_tag), 64'(e.t));
          if (out_ready) q32.delete(0);
        end
      end
      if (in_valid && in_ready) begin
        e.p = mref(64'(in_a), 64'(in_b), in_signed, 32);
        e.t = in_tag;
        q32.push_back(e);
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v8s) begin
        if (q8s.size() == 0) chk("extra8s", 64'd1, 64'd0);
        else begin
          e = q8s.pop_front();
          chk("p8s", 64'(p8s), e.p);
          chk("tag8s", 64'(t8s), 64'(e.t[0]));
        end
      end
      if (v8u) begin
        if (q8u.size() == 0) chk("extra8u", 64'd1, 64'd0);
        else begin
          e = q8u.pop_front();
          chk("p8u", 64'(p8u), e.p);
          chk("tag8u", 64'(t8u), 64'(e.t[0]));
        end
      end
      if (v16) begin
        if (q16.size() == 0) chk("extra16", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          chk("p16", 64'(p16), e.p);
          chk("tag16", 64'(t16), 64'(e.t));
        end
      end
      e.t = s_tag;
      if (s_valid && r8s) begin
        e.p = mref(64'(s_a8), 64'(s_b8), 1'b1, 8);
        q8s.push_back(e);
      end
      if (s_valid && r8u) begin
        e.p = mref(64'(s_a8), 64'(s_b8), 1'b0, 8);
        q8u.push_back(e);
      end
      if (s_valid && r16) begin
        e.p = mref(64'(s_a16), 64'(s_b16), s_sg16, 16);
        q16.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic s, input logic [3:0] t,
                    input logic [63:0] exp, input string nm);
    int lat;
    lat = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_signed = s;
    in_tag = t;
    do begin
      cyc();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    chk({nm, "_lat"}, 64'(lat), 64'd4);
    chk(nm, out_p, exp);
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    cyc();
    chk({nm, "_gone"}, 64'(out_valid), 64'd0);
  endtask

  task automatic rnd32();
    in_valid = 1'b1;
    in_a = $urandom;
    in_b = $urandom;
    in_signed = 1'($urandom);
    in_tag = 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int cnt;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_signed = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    s_valid = 1'b0;
    s_oready = 1'b1;
    s_a8 = '0;
    s_b8 = '0;
    s_a16 = '0;
    s_b16 = '0;
    s_sg16 = 1'b0;
    s_tag = '0;
    repeat (3) cyc();
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_p", out_p, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("rdy_after_rst", 64'(in_ready), 64'd1);

    op(32'hFFFF_FFF9, 32'd6, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFD6, "m7x6");
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd5,
       64'h4000_0000_0000_0000, "minxmin");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd6,
       64'hFFFF_FFFE_0000_0001, "umax2");
    op(32'd0, 32'hFFFF_FFFF, 1'b1, 4'd7, 64'd0, "zero");
    op(32'hFFFF_FFFF, 32'd2, 1'b0, 4'd8, 64'h1_FFFF_FFFE, "umaxx2");
    op(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFE, "m1x2");
    op(32'd7, 32'hFFFF_FFFA, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFD6, "7xm6");

    for (int i = 0; i < 100; i++) begin
      rnd32();
      chk("stream_rdy", 64'(in_ready), 64'd1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("stream_drain", 64'(q32.size()), 64'd0);

    out_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      rnd32();
      cyc();
    end
    chk("bp_acc", 64'(n_acc - acc0), 64'd4);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();
    chk("bp_drain", 64'(q32.size()), 64'd0);
    chk("bp_total", 64'(n_acc - acc0), 64'd4);

    for (int i = 0; i < 3; i++) begin
      rnd32();
      cyc();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_ov", 64'(out_valid), 64'd0);
    chk("rstmid_p", out_p, 64'd0);
    chk("rstmid_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid) cnt++;
    end
    chk("rstmid_flush", 64'(cnt), 64'd0);
    op(32'd1234, 32'hFFFF_FFFF, 1'b1, 4'hA,
       64'hFFFF_FFFF_FFFF_FB2E, "post_rst");

    s_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      s_a8 = 8'(i >> 8);
      s_b8 = 8'(i);
      s_a16 = 16'($urandom);
      s_b16 = 16'($urandom);
      s_sg16 = 1'($urandom);
      s_tag = 4'($urandom);
      if (!(r8s && r8u && r16)) chk("sweep_rdy", 64'd0, 64'd1);
      cyc();
    end
    s_valid = 1'b0;
    repeat (8) cyc();
    chk("drain8s", 64'(q8s.size()), 64'd0);
    chk("drain8u", 64'(q8u.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
